// File: rtl/kgp_pkg.sv
// Shared KGP-RISC encodings: opcodes, R-type functs, ALU operation codes,
// control FSM states and decoded instruction classes.
package kgp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_BR    = 6'b000100;
  localparam logic [5:0] OP_BZ    = 6'b000101;
  localparam logic [5:0] OP_BNZ   = 6'b000110;
  localparam logic [5:0] OP_BLTZ  = 6'b000111;
  localparam logic [5:0] OP_BCY   = 6'b001000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD  = 6'd0;
  localparam logic [5:0] FN_COMP = 6'd1;
  localparam logic [5:0] FN_AND  = 6'd2;
  localparam logic [5:0] FN_XOR  = 6'd3;
  localparam logic [5:0] FN_SLL  = 6'd4;
  localparam logic [5:0] FN_SRL  = 6'd5;
  localparam logic [5:0] FN_SRA  = 6'd6;

  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_COMP   = 6'b000001;
  localparam logic [5:0] ALU_AND    = 6'b000010;
  localparam logic [5:0] ALU_XOR    = 6'b000011;
  localparam logic [5:0] ALU_SLL    = 6'b000100;
  localparam logic [5:0] ALU_SRL    = 6'b000101;
  localparam logic [5:0] ALU_SRA    = 6'b000110;
  localparam logic [5:0] ALU_CHKZ   = 6'b000111;
  localparam logic [5:0] ALU_CHKLTZ = 6'b001000;
  localparam logic [5:0] ALU_IDLE   = 6'b111111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR
  } kgp_state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_BZ,
    CLS_BNZ,
    CLS_BLTZ,
    CLS_BCY,
    CLS_HALT,
    CLS_ILL
  } kgp_cls_e;

  function automatic logic cls_is_branch(input kgp_cls_e c);
    return (c == CLS_BR) || (c == CLS_BZ) || (c == CLS_BNZ) ||
           (c == CLS_BLTZ) || (c == CLS_BCY);
  endfunction

endpackage

// File: rtl/kgp_ctrl_decode.sv
// Combinational instruction decoder: maps the latched instruction word to an
// instruction class, the ALU operation used in EXEC, and an illegal flag.
module kgp_ctrl_decode
  import kgp_pkg::*;
(
  input  logic [31:0] i_ir,
  output kgp_cls_e    o_cls,
  output logic [5:0]  o_alu_op,
  output logic        o_illegal
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused_ir;

  assign w_op        = i_ir[31:26];
  assign w_funct     = i_ir[5:0];
  assign w_unused_ir = ^i_ir[25:6];

  always_comb begin
    o_cls    = CLS_ILL;
    o_alu_op = ALU_IDLE;
    case (w_op)
      OP_RTYPE: begin
        if (w_funct <= FN_SRA) begin
          o_cls    = CLS_R;
          o_alu_op = w_funct;
        end
      end
      OP_ADDI: begin
        o_cls    = CLS_ADDI;
        o_alu_op = ALU_ADD;
      end
      OP_LW: begin
        o_cls    = CLS_LW;
        o_alu_op = ALU_ADD;
      end
      OP_SW: begin
        o_cls    = CLS_SW;
        o_alu_op = ALU_ADD;
      end
      OP_BR:   o_cls = CLS_BR;
      OP_BZ: begin
        o_cls    = CLS_BZ;
        o_alu_op = ALU_CHKZ;
      end
      OP_BNZ: begin
        o_cls    = CLS_BNZ;
        o_alu_op = ALU_CHKZ;
      end
      OP_BLTZ: begin
        o_cls    = CLS_BLTZ;
        o_alu_op = ALU_CHKLTZ;
      end
      OP_BCY:  o_cls = CLS_BCY;
      OP_HALT: o_cls = CLS_HALT;
      default: o_cls = CLS_ILL;
    endcase
  end

  assign o_illegal = (o_cls == CLS_ILL);

endmodule

// File: rtl/kgp_ctrl_fsm.sv
// Multi-cycle KGP-RISC control unit (FETCH/DECODE/EXEC/MEM/WB, HALT/ERR terminal).
// Define KGP_PERF_CNT_EN to add the cycle_cnt / retired_cnt performance counters.
module kgp_ctrl_fsm
  import kgp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef KGP_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_carry,
  output logic [5:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_wr_en,
  output logic        wb_sel_mem,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        pc_wr_en,
  output logic        pc_sel_branch,
  output logic        halted,
`ifdef KGP_PERF_CNT_EN
  output logic        err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`else
  output logic        err
`endif
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  kgp_state_e       r_state;
  logic [31:0]      r_ir;
  logic             r_carry_q;
  logic [TMO_W-1:0] r_tmo;

  kgp_cls_e   w_cls;
  logic [5:0] w_dec_alu_op;
  logic       w_illegal;
  logic       w_taken;
  logic       w_is_branch;

  logic [5:0] w_alu_op;
  logic       w_alu_src_imm;
  logic       w_reg_wr_en;
  logic       w_wb_sel_mem;
  logic       w_mem_rd_en;
  logic       w_mem_wr_en;
  logic       w_pc_wr_en;
  logic       w_pc_sel_branch;
  logic       w_halted;
  logic       w_err;

  kgp_ctrl_decode u_decode (
    .i_ir      (r_ir),
    .o_cls     (w_cls),
    .o_alu_op  (w_dec_alu_op),
    .o_illegal (w_illegal)
  );

  assign w_is_branch = cls_is_branch(w_cls);

  // Flags come straight from the ALU in the EXEC cycle; BCY uses the saved carry.
  always_comb begin
    w_taken = 1'b0;
    case (w_cls)
      CLS_BR:   w_taken = 1'b1;
      CLS_BZ:   w_taken = alu_zero;
      CLS_BNZ:  w_taken = !alu_zero;
      CLS_BLTZ: w_taken = alu_lt;
      CLS_BCY:  w_taken = r_carry_q;
      default:  w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_ir      <= '0;
      r_carry_q <= 1'b0;
      r_tmo     <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_illegal)              r_state <= ST_ERR;
          else if (w_cls == CLS_HALT) r_state <= ST_HALT;
          else                        r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (w_cls)
            CLS_R, CLS_ADDI: begin
              r_state <= ST_WB;
              if (w_dec_alu_op == ALU_ADD || w_dec_alu_op == ALU_COMP)
                r_carry_q <= alu_carry;
            end
            CLS_LW, CLS_SW: begin
              r_state <= ST_MEM;
              r_tmo   <= '0;
            end
            default: r_state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem_ready)              r_state <= (w_cls == CLS_LW) ? ST_WB : ST_FETCH;
          else if (r_tmo == TMO_LAST) r_state <= ST_ERR;
          else                        r_tmo   <= r_tmo + 1'b1;
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_ERR;
      endcase
    end
  end

  // Outputs follow state + ir; only the branch select and the SW retire pulse
  // also look at same-cycle ALU flags / mem_ready.
  always_comb begin
    w_alu_op        = ALU_IDLE;
    w_alu_src_imm   = 1'b0;
    w_reg_wr_en     = 1'b0;
    w_wb_sel_mem    = 1'b0;
    w_mem_rd_en     = 1'b0;
    w_mem_wr_en     = 1'b0;
    w_pc_wr_en      = 1'b0;
    w_pc_sel_branch = 1'b0;
    w_halted        = 1'b0;
    w_err           = 1'b0;
    case (r_state)
      ST_EXEC: begin
        w_alu_op      = w_dec_alu_op;
        w_alu_src_imm = (w_cls == CLS_ADDI) || (w_cls == CLS_LW) || (w_cls == CLS_SW);
        if (w_is_branch) begin
          w_pc_wr_en      = 1'b1;
          w_pc_sel_branch = w_taken;
        end
      end
      ST_MEM: begin
        w_mem_rd_en = (w_cls == CLS_LW);
        w_mem_wr_en = (w_cls == CLS_SW);
        w_pc_wr_en  = (w_cls == CLS_SW) && mem_ready;
      end
      ST_WB: begin
        w_reg_wr_en  = 1'b1;
        w_wb_sel_mem = (w_cls == CLS_LW);
        w_pc_wr_en   = 1'b1;
      end
      ST_HALT: w_halted = 1'b1;
      ST_ERR:  w_err    = 1'b1;
      default: ;
    endcase
  end

  assign alu_op        = w_alu_op;
  assign alu_src_imm   = w_alu_src_imm;
  assign reg_wr_en     = w_reg_wr_en;
  assign wb_sel_mem    = w_wb_sel_mem;
  assign mem_rd_en     = w_mem_rd_en;
  assign mem_wr_en     = w_mem_wr_en;
  assign pc_wr_en      = w_pc_wr_en;
  assign pc_sel_branch = w_pc_sel_branch;
  assign halted        = w_halted;
  assign err           = w_err;

`ifdef KGP_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retired_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (r_state != ST_HALT && r_state != ST_ERR)
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_pc_wr_en)
        r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// Randomized bench for kgp_ctrl_fsm: each instruction is expanded into an
// expected per-cycle output trace by an instruction-level model.
module tb_kgp_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic        alu_zero;
  logic        alu_lt;
  logic        alu_carry;
  logic [5:0]  alu_op;
  logic        alu_src_imm;
  logic        reg_wr_en;
  logic        wb_sel_mem;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic        pc_wr_en;
  logic        pc_sel_branch;
  logic        halted;
  logic        err;
`ifdef KGP_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  kgp_ctrl_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .mem_ready     (mem_ready),
    .alu_zero      (alu_zero),
    .alu_lt        (alu_lt),
    .alu_carry     (alu_carry),
    .alu_op        (alu_op),
    .alu_src_imm   (alu_src_imm),
    .reg_wr_en     (reg_wr_en),
    .wb_sel_mem    (wb_sel_mem),
    .mem_rd_en     (mem_rd_en),
    .mem_wr_en     (mem_wr_en),
    .pc_wr_en      (pc_wr_en),
    .pc_sel_branch (pc_sel_branch),
    .halted        (halted),
    .err           (err)
`ifdef KGP_PERF_CNT_EN
    , .cycle_cnt   (cycle_cnt),
    .retired_cnt   (retired_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {alu_op, alu_src_imm, reg_wr_en, wb_sel_mem, mem_rd_en, mem_wr_en, pc_wr_en, pc_sel_branch, halted, err}
  logic [14:0] obs;
  assign obs = {alu_op, alu_src_imm, reg_wr_en, wb_sel_mem, mem_rd_en, mem_wr_en,
                pc_wr_en, pc_sel_branch, halted, err};

  localparam logic [14:0] V_IDLE = {6'h3F, 9'b0};
  localparam logic [14:0] V_HALT = {6'h3F, 9'b000000010};
  localparam logic [14:0] V_ERR  = {6'h3F, 9'b000000001};
  localparam int          TMO    = 16;

  function automatic logic [14:0] ov(input logic [5:0] aop, input logic src, input logic rg,
                                     input logic wbm, input logic rd, input logic wr,
                                     input logic pcw, input logic sel);
    return {aop, src, rg, wbm, rd, wr, pcw, sel, 2'b00};
  endfunction

  typedef struct {
    logic        iv;
    logic        mr;
    logic [14:0] ex;
  } cyc_t;

  cyc_t q[$];
  logic carry_m;
  int   retired_m;

  task automatic push(input logic iv, input logic mr, input logic [14:0] ex);
    cyc_t c;
    c.iv = iv;
    c.mr = mr;
    c.ex = ex;
    q.push_back(c);
  endtask

  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 check_val({tag, "_rst_async"}, {17'd0, obs}, {17'd0, V_IDLE});
    @(posedge clk);
    #1 check_val({tag, "_rst_hold"}, {17'd0, obs}, {17'd0, V_IDLE});
    rst_n     = 1'b1;
    carry_m   = 1'b0;
    retired_m = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    alu_zero    = 1'b0;
    alu_lt      = 1'b0;
    alu_carry   = 1'b0;
    carry_m     = 1'b0;
    retired_m   = 0;
    #12;
    check_val("reset_outputs", {17'd0, obs}, {17'd0, V_IDLE});
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      int          code;
      int          pick;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] rnd;
      logic [31:0] iw;
      logic        z, lt, cy, taken, term, abort;
      int          nwait, lat, abort_at;
      logic [5:0]  baop;

      pick = $urandom_range(0, 99);
      if      (pick < 25) code = 0;
      else if (pick < 35) code = 1;
      else if (pick < 46) code = 2;
      else if (pick < 57) code = 3;
      else if (pick < 62) code = 4;
      else if (pick < 68) code = 5;
      else if (pick < 74) code = 6;
      else if (pick < 80) code = 7;
      else if (pick < 88) code = 8;
      else if (pick < 92) code = 9;
      else                code = 10;

      fn = 6'($urandom_range(0, 63));
      if (code <= 8)       op = 6'(code);
      else if (code == 9)  op = 6'h3F;
      else                 op = 6'($urandom_range(9, 62));
      if (code == 0) fn = 6'($urandom_range(0, 6));
      // Some illegal cases are R-type with an undefined funct.
      if (code == 10 && $urandom_range(0, 2) == 0) begin
        op = 6'd0;
        fn = 6'($urandom_range(7, 63));
      end
      rnd = $urandom();
      iw  = {op, rnd[25:6], fn};

      z  = 1'($urandom_range(0, 1));
      lt = 1'($urandom_range(0, 1));
      cy = 1'($urandom_range(0, 1));
      nwait = $urandom_range(0, 3);
      lat   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 5);
      term  = 1'b0;

      q.delete();
      for (int w = 0; w < nwait; w++) push(1'b0, 1'b0, V_IDLE);
      push(1'b1, 1'b0, V_IDLE);
      push(1'b0, 1'b0, V_IDLE);

      case (code)
        0, 1: begin
          push(1'b0, 1'b0, ov((code == 0) ? fn : 6'd0, code == 1, 0, 0, 0, 0, 0, 0));
          push(1'b0, 1'b0, ov(6'h3F, 0, 1, 0, 0, 0, 1, 0));
          retired_m++;
          if (code == 1 || fn <= 6'd1) carry_m = cy;
        end
        2, 3: begin
          push(1'b0, 1'b0, ov(6'd0, 1, 0, 0, 0, 0, 0, 0));
          if (lat == 0) begin
            for (int m = 0; m < TMO; m++)
              push(1'b0, 1'b0, ov(6'h3F, 0, 0, 0, code == 2, code == 3, 0, 0));
            for (int t = 0; t < 3; t++) push(1'b0, 1'b0, V_ERR);
            term = 1'b1;
          end else begin
            for (int m = 1; m < lat; m++)
              push(1'b0, 1'b0, ov(6'h3F, 0, 0, 0, code == 2, code == 3, 0, 0));
            push(1'b0, 1'b1, ov(6'h3F, 0, 0, 0, code == 2, code == 3, code == 3, 0));
            if (code == 2) push(1'b0, 1'b0, ov(6'h3F, 0, 1, 1, 0, 0, 1, 0));
            retired_m++;
          end
        end
        4, 5, 6, 7, 8: begin
          case (code)
            4:       begin baop = 6'h3F; taken = 1'b1;     end
            5:       begin baop = 6'd7;  taken = z;        end
            6:       begin baop = 6'd7;  taken = !z;       end
            7:       begin baop = 6'd8;  taken = lt;       end
            default: begin baop = 6'h3F; taken = carry_m;  end
          endcase
          push(1'b0, 1'b0, ov(baop, 0, 0, 0, 0, 0, 1, taken));
          retired_m++;
        end
        9: begin
          for (int t = 0; t < 3; t++) push(1'b0, 1'b0, V_HALT);
          term = 1'b1;
        end
        default: begin
          for (int t = 0; t < 3; t++) push(1'b0, 1'b0, V_ERR);
          term = 1'b1;
        end
      endcase

      abort    = !term && ($urandom_range(0, 9) == 0);
      abort_at = $urandom_range(0, q.size() - 1);

      alu_zero  = z;
      alu_lt    = lt;
      alu_carry = cy;
      for (int j = 0; j < q.size(); j++) begin
        instr_valid = q[j].iv;
        mem_ready   = q[j].mr;
        instr       = q[j].iv ? iw : $urandom();
        @(negedge clk);
        check_val($sformatf("i%0d_op%0h_c%0d", n, op, j), {17'd0, obs}, {17'd0, q[j].ex});
        if (abort && j == abort_at) break;
        @(posedge clk);
        #1;
      end
      instr_valid = 1'b0;
      mem_ready   = 1'b0;

      if (term || abort) begin
        do_reset($sformatf("i%0d", n));
      end else begin
`ifdef KGP_PERF_CNT_EN
        check_val($sformatf("i%0d_retired", n), retired_cnt, 32'(retired_m));
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
